// File: rtl/cam_frame_capture.sv
// rtl/cam_frame_capture.sv - OV7670 byte capture, RGB332 conversion and double-buffered frame-store writer
// Camera pins are sampled as data on CLK; frames are validated before the display bank is swapped.
module cam_frame_capture #(
  parameter int WIDTH       = 176,
  parameter int HEIGHT      = 144,
  parameter int ADDR_W      = 15,
  parameter int DECIM       = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              CAM_PCLK,
  input  logic              CAM_HREF,
  input  logic              CAM_VSYNC,
  input  logic [7:0]        CAM_DATA,
  input  logic [1:0]        MODE,
  input  logic              CAPTURE_EN,
  output logic [ADDR_W-1:0] W_ADDR,
  output logic [7:0]        W_DATA,
  output logic              W_EN,
  output logic              W_BANK,
  output logic              BANK,
  output logic              FRAME_DONE,
  output logic              FRAME_ERR
);

  localparam int XW = $clog2(WIDTH + 2);
  localparam int YW = $clog2(HEIGHT + 2);
  localparam logic [XW-1:0]     X_LIM    = XW'(WIDTH);
  localparam logic [XW-1:0]     X_SAT    = XW'(WIDTH + 1);
  localparam logic [YW-1:0]     Y_LIM    = YW'(HEIGHT);
  localparam logic [YW-1:0]     Y_SAT    = YW'(HEIGHT + 1);
  localparam logic [2:0]        D_TOP    = 3'(DECIM - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(WIDTH);

  typedef enum logic [1:0] {IDLE, ARMED, FRAME, END_S} state_t;
  state_t state;

  logic [SYNC_STAGES-1:0] pclk_sync, href_sync, vsync_sync;
  logic [7:0]             data_sync [SYNC_STAGES];
  logic                   pclk_q, pclk_rise, href_q, href_q2, vsync_q, vsync_q2;
  logic [7:0]             data_q, b0, pix;
  logic [1:0]             mode_r;
  logic                   phase, bad;
  logic [XW-1:0]          x_cnt;
  logic [YW-1:0]          y_cnt;
  logic [2:0]             xdec, ydec;
  logic [ADDR_W-1:0]      row_base;
  logic                   href_fall, vsync_fall, vsync_rise, frame_start, keep, in_bounds;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pclk_sync  <= '0;
      href_sync  <= '0;
      vsync_sync <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) data_sync[i] <= '0;
      pclk_q     <= 1'b0;
      pclk_rise  <= 1'b0;
      href_q     <= 1'b0;
      href_q2    <= 1'b0;
      vsync_q    <= 1'b0;
      vsync_q2   <= 1'b0;
      data_q     <= '0;
    end else begin
      pclk_sync  <= {pclk_sync[SYNC_STAGES-2:0], CAM_PCLK};
      href_sync  <= {href_sync[SYNC_STAGES-2:0], CAM_HREF};
      vsync_sync <= {vsync_sync[SYNC_STAGES-2:0], CAM_VSYNC};
      data_sync[0] <= CAM_DATA;
      for (int i = 1; i < SYNC_STAGES; i++) data_sync[i] <= data_sync[i-1];
      // Edge flop delays the rise by one CLK; href/vsync/data ride along so they stay aligned with it.
      pclk_q     <= pclk_sync[SYNC_STAGES-1];
      pclk_rise  <= pclk_sync[SYNC_STAGES-1] & ~pclk_q;
      href_q     <= href_sync[SYNC_STAGES-1];
      href_q2    <= href_q;
      vsync_q    <= vsync_sync[SYNC_STAGES-1];
      vsync_q2   <= vsync_q;
      data_q     <= data_sync[SYNC_STAGES-1];
    end
  end

  assign href_fall   = href_q2 & ~href_q;
  assign vsync_fall  = vsync_q2 & ~vsync_q;
  assign vsync_rise  = ~vsync_q2 & vsync_q;
  assign frame_start = vsync_fall && ((state == ARMED && CAPTURE_EN) || state == FRAME);
  assign keep        = (xdec == 3'd0) && (ydec == 3'd0);
  assign in_bounds   = (x_cnt < X_LIM) && (y_cnt < Y_LIM);

  always_comb begin
    pix = {b0[7:5], b0[2:0], data_q[4:3]};
    case (mode_r)
      2'd1:    pix = {b0[3:1], data_q[7:5], data_q[3:2]};
      2'd2:    pix = {data_q[7:5], data_q[7:5], data_q[7:6]};
      default: pix = {b0[7:5], b0[2:0], data_q[4:3]};
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= IDLE;
      W_ADDR     <= '0;
      W_DATA     <= '0;
      W_EN       <= 1'b0;
      W_BANK     <= 1'b1;
      BANK       <= 1'b0;
      FRAME_DONE <= 1'b0;
      FRAME_ERR  <= 1'b0;
      mode_r     <= '0;
      b0         <= '0;
      phase      <= 1'b0;
      bad        <= 1'b0;
      x_cnt      <= '0;
      y_cnt      <= '0;
      xdec       <= '0;
      ydec       <= '0;
      row_base   <= '0;
    end else begin
      W_EN       <= 1'b0;
      FRAME_DONE <= 1'b0;
      FRAME_ERR  <= 1'b0;
      case (state)
        IDLE:  if (CAPTURE_EN) state <= ARMED;
        ARMED: if (!CAPTURE_EN) state <= IDLE;
        FRAME: begin
          if (pclk_rise && href_q) begin
            phase <= ~phase;
            if (!phase) begin
              b0 <= data_q;
            end else begin
              if (keep) begin
                if (in_bounds) begin
                  W_EN   <= 1'b1;
                  W_ADDR <= row_base + ADDR_W'(x_cnt);
                  W_DATA <= pix;
                end else begin
                  bad <= 1'b1;
                end
                if (x_cnt != X_SAT) x_cnt <= x_cnt + 1'b1;
              end
              xdec <= (xdec == 3'd0) ? D_TOP : xdec - 3'd1;
            end
          end
          if (href_fall) begin
            phase <= 1'b0;
            x_cnt <= '0;
            xdec  <= '0;
            if (phase) bad <= 1'b1;
            if (ydec == 3'd0) begin
              if (y_cnt != Y_SAT) y_cnt <= y_cnt + 1'b1;
              row_base <= row_base + ROW_STEP;
              if (x_cnt != X_LIM) bad <= 1'b1;
            end
            ydec <= (ydec == 3'd0) ? D_TOP : ydec - 3'd1;
          end
          if (vsync_rise) state <= END_S;
        end
        END_S: begin
          // Counters already include any line that ended in the same cycle as the vsync rise.
          if (!bad && y_cnt == Y_LIM) begin
            FRAME_DONE <= 1'b1;
            BANK       <= ~BANK;
            W_BANK     <= BANK;
          end else begin
            FRAME_ERR  <= 1'b1;
          end
          state <= CAPTURE_EN ? ARMED : IDLE;
        end
        default: state <= IDLE;
      endcase
      if (frame_start) begin
        state    <= FRAME;
        mode_r   <= MODE;
        phase    <= 1'b0;
        bad      <= 1'b0;
        x_cnt    <= '0;
        y_cnt    <= '0;
        xdec     <= '0;
        ydec     <= '0;
        row_base <= '0;
      end
    end
  end

endmodule
